debug_port_uart_tx: RTL and testbench
=====================================

Name: debug_port_uart_tx

Overview:
- Host-facing transmitter for the CPU's seven 8-bit debug ports.
- On a trigger, snapshots debug_port1..7 and sends them to the serial-port debugger as one framed packet: sync byte followed by the seven port bytes.
- Uses standard 8N1 UART, LSB first.
- Sits at top level between cpu and the board's UART TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
SYNC_BYTE, 8'hA5, first byte of every packet

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
trigger  input  1  request a packet; level-sampled, accepted only when busy=0
debug_port1  input  8  packet byte 1 (after sync)
debug_port2  input  8  packet byte 2
debug_port3  input  8  packet byte 3
debug_port4  input  8  packet byte 4
debug_port5  input  8  packet byte 5
debug_port6  input  8  packet byte 6
debug_port7  input  8  packet byte 7
uart_tx  output  1  serial line; idle high
busy  output  1  packet in progress
done  output  1  one-cycle pulse when final stop bit completes

Behaviour:
- All outputs are registered.
- Reset, asynchronous, any time including mid-packet:
  - uart_tx=1, busy=0, done=0.
  - FSM=IDLE; baud counter, bit index and byte index cleared.
  - Partial frame is abandoned with no further edges.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On an edge where trigger=1, capture debug_port1..7 into a 7-byte shadow register.
  - Same edge: load current byte = SYNC_BYTE, byte index=0, busy<=1, uart_tx<=0, go to START.
  - uart_tx therefore falls on the first edge after trigger is sampled.
- Ports may change freely after capture; the packet always carries the captured values.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit holds exactly CLKS_PER_BIT cycles, and the state advances when the counter wraps.
- START: holds uart_tx=0 for one bit, then goes to DATA with bit index 0.
- DATA:
  - uart_tx = current_byte[bit index], LSB first.
  - After bit 7 completes, go to STOP with uart_tx=1.
- STOP: holds uart_tx=1 for one bit. On completion:
  - If byte index < 7: byte index+1, load shadow[byte index], uart_tx<=0, go to START. There is no inter-byte idle gap.
  - If byte index == 7: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Packet length: 8 bytes × 10 bits × CLKS_PER_BIT cycles, measured from the trigger-sampling edge to the done edge.
- Trigger rules:
  - Trigger while busy=1 is ignored; it is not queued.
  - Trigger high during the done cycle is accepted (busy=0), giving back-to-back packets separated by zero idle bits.
  - Holding trigger high continuously streams packets.
- done and busy are never both 1.

Optional Feature:
- Macro: DEBUG_TX_CHECKSUM_EN.
- When defined:
  - A ninth byte is appended after debug_port7: XOR of the seven captured port bytes. SYNC_BYTE is excluded.
  - The last byte index is 8.
  - Packet length is 9 × 10 × CLKS_PER_BIT cycles.
  - done fires after the checksum stop bit.
- When undefined: 8-byte packet exactly as above, and no checksum logic is present.

Test Plan:
1. Reset behaviour: assert reset mid-DATA of byte 3 -> same cycle uart_tx=1, busy=0, done=0. After release, uart_tx stays 1 with no trigger.
2. Single packet: CLKS_PER_BIT=4, ports=01,02,03,04,05,06,07, pulse trigger 1 cycle ->
   - uart_tx low on the next edge.
   - Decoded bytes A5,01,02,03,04,05,06,07, each with start=0 and stop=1.
   - done pulses exactly 320 cycles after the trigger edge; busy high for those 320 cycles.
3. Snapshot: change all ports to FF one cycle after trigger -> decoded packet still A5,01..07.
4. Busy trigger: pulse trigger at cycle 100 of a packet -> ignored; no second packet; done pulses once.
5. Back-to-back: hold trigger high for 700 cycles (CLKS_PER_BIT=4) ->
   - Second packet's start bit begins on the edge after done, with no idle bit.
   - Two complete packets decoded; a third is in progress when trigger drops.
6. With DEBUG_TX_CHECKSUM_EN: ports=01,02,04,08,10,20,40 -> decoded A5,01,02,04,08,10,20,40,7F; done at 360 cycles (CLKS_PER_BIT=4).

Source files
------------

// File: rtl/debug_port_uart_tx.sv
// debug_port_uart_tx
// Snapshots the seven 8-bit CPU debug ports on a trigger and sends them to the
// host debugger as one 8N1 UART packet (LSB first): SYNC_BYTE, then port1..7.
// Optional feature macro: DEBUG_TX_CHECKSUM_EN appends a ninth byte holding
// the XOR of the seven captured port bytes (SYNC_BYTE excluded).
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   trigger             packet request, level-sampled, accepted only while idle
//   debug_port1..7 [7:0] packet payload bytes, captured on acceptance
//   uart_tx             serial line, idle high
//   busy                packet in progress
//   done                one-cycle pulse when the final stop bit completes
module debug_port_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [3:0]       r_byte_idx;
  logic [7:0]       r_cur;
  logic [7:0]       r_shadow [7];
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic       w_wrap;
  logic [7:0] w_next_byte;

  assign w_wrap  = (r_cnt == CNT_MAX);
  assign uart_tx = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;

  // Byte following the one just sent; r_byte_idx is the index of the sent byte
  // (0 = sync), so it directly selects the next shadow entry.
  always_comb begin
    w_next_byte = r_shadow[0];
    case (r_byte_idx)
      4'd0:    w_next_byte = r_shadow[0];
      4'd1:    w_next_byte = r_shadow[1];
      4'd2:    w_next_byte = r_shadow[2];
      4'd3:    w_next_byte = r_shadow[3];
      4'd4:    w_next_byte = r_shadow[4];
      4'd5:    w_next_byte = r_shadow[5];
      4'd6:    w_next_byte = r_shadow[6];
`ifdef DEBUG_TX_CHECKSUM_EN
      4'd7:    w_next_byte = r_csum;
`endif
      default: w_next_byte = r_shadow[0];
    endcase
  end

  // Packet FSM with baud counter; all outputs registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_cur      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < 7; i++) r_shadow[i] <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // Every non-idle state spends exactly CLKS_PER_BIT cycles per bit.
      if (r_state != IDLE) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);

      case (r_state)
        IDLE: begin
          if (trigger) begin
            r_shadow[0] <= debug_port1;
            r_shadow[1] <= debug_port2;
            r_shadow[2] <= debug_port3;
            r_shadow[3] <= debug_port4;
            r_shadow[4] <= debug_port5;
            r_shadow[5] <= debug_port6;
            r_shadow[6] <= debug_port7;
`ifdef DEBUG_TX_CHECKSUM_EN
            r_csum      <= debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                           debug_port5 ^ debug_port6 ^ debug_port7;
`endif
            r_cur       <= SYNC_BYTE;
            r_byte_idx  <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_tx        <= 1'b0;
            r_state     <= START;
          end
        end
        START: begin
          if (w_wrap) begin
            r_bit   <= '0;
            r_tx    <= r_cur[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_wrap) begin
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_cur[3'(r_bit + 3'd1)];
            end
          end
        end
        STOP: begin
          if (w_wrap) begin
            if (r_byte_idx == LAST_IDX) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              // Next start bit follows immediately: no inter-byte gap.
              r_byte_idx <= r_byte_idx + 4'd1;
              r_cur      <= w_next_byte;
              r_tx       <= 1'b0;
              r_state    <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_port_uart_tx.sv
// Scoreboard bench for debug_port_uart_tx: a packet-level model pushes the
// expected bytes and done cycle on every accepted trigger; a monitor decodes
// uart_tx and checks busy/done every cycle.
module tb_debug_port_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int unsigned NB      = 9;
  localparam int unsigned PKT_LIT = 360;
`else
  localparam int unsigned NB      = 8;
  localparam int unsigned PKT_LIT = 320;
`endif
  localparam int unsigned PKT = NB * 10 * CPB;

  logic       clk, reset, trigger;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7;
  logic       uart_tx, busy, done;

  debug_port_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .debug_port1(p1), .debug_port2(p2), .debug_port3(p3), .debug_port4(p4),
    .debug_port5(p5), .debug_port6(p6), .debug_port7(p7),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          m_busy = 0;
  bit          m_expect_low = 0;
  int unsigned m_end = 0;
  logic [7:0]  bq[$];
  int unsigned dq[$];
  int unsigned last_accept = 0, last_done = 0;
  int          n_accept = 0, n_done = 0;
  bit          dec_active = 0;
  int          dec_t = 0;
  logic [7:0]  dec_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: packet-level view of triggers, bytes and packet length.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_expect_low = 0;
      bq.delete();
      dq.delete();
    end else if (m_busy) begin
      if (cyc == m_end) m_busy = 0;
    end else if (trigger) begin
      logic [7:0] cs;
      cs = p1 ^ p2 ^ p3 ^ p4 ^ p5 ^ p6 ^ p7;
      bq.push_back(8'hA5);
      bq.push_back(p1); bq.push_back(p2); bq.push_back(p3); bq.push_back(p4);
      bq.push_back(p5); bq.push_back(p6); bq.push_back(p7);
      if (NB == 9) bq.push_back(cs);
      m_end = cyc + PKT;
      dq.push_back(m_end);
      m_busy = 1;
      m_expect_low = 1;
      last_accept = cyc;
      n_accept++;
    end
  end

  // Monitor: busy/done each cycle, start-edge timing, UART byte decoder.
  initial forever begin
    bit exp_done;
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    exp_done = (dq.size() > 0 && dq[0] == cyc);
    if (exp_done) void'(dq.pop_front());
    chk("done", 32'(done), 32'(exp_done));
    if (done) begin n_done++; last_done = cyc; end
    if (m_expect_low) begin
      chk("start_edge", 32'(uart_tx), 32'd0);
      m_expect_low = 0;
    end
    if (reset) dec_active = 0;
    else if (!dec_active) begin
      if (uart_tx == 1'b0) begin dec_active = 1; dec_t = 0; end
    end else dec_t++;
    if (dec_active && (dec_t % CPB) == CPB / 2) begin
      int k;
      k = dec_t / CPB;
      if (k == 0) chk("start_bit", 32'(uart_tx), 32'd0);
      else if (k <= 8) dec_byte[3'(k - 1)] = uart_tx;
      else begin
        chk("stop_bit", 32'(uart_tx), 32'd1);
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL byte: got unexpected 0x%0h expected none (cycle %0d)", dec_byte, cyc);
        end else chk("byte", 32'(dec_byte), 32'(bq.pop_front()));
        dec_active = 0;
      end
    end
  end

  task automatic set_ports(input logic [7:0] a, b, c, d, e, f, g);
    p1 = a; p2 = b; p3 = c; p4 = d; p5 = e; p6 = f; p7 = g;
  endtask

  task automatic pulse;
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic wait_idle;
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!m_busy && !dec_active) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got busy expected idle (cycle %0d)", cyc);
    end
    repeat (2) @(negedge clk);
    chk("bytes_left", 32'(bq.size()), 32'd0);
  endtask

  initial begin
    int a0, d0, exp_n;
    reset = 1'b1; trigger = 1'b0;
    set_ports(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(uart_tx), 32'd1);

    // Single packet with known ports and exact length.
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    pulse();
    wait_idle();
    chk("pkt_len", last_done - last_accept, PKT_LIT);

    // Reset mid-DATA of byte 3, then quiet line.
    set_ports(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom));
    pulse();
    repeat (129) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_rst_tx", 32'(uart_tx), 32'd1);

    // Snapshot: ports change right after capture.
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    set_ports(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_idle();

    // Trigger while busy is ignored.
    a0 = n_accept; d0 = n_done;
    set_ports(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77);
    pulse();
    repeat (98) @(negedge clk);
    pulse();
    wait_idle();
    chk("busy_trig_accepts", 32'(n_accept - a0), 32'd1);
    chk("busy_trig_dones", 32'(n_done - d0), 32'd1);

    // Back-to-back streaming with trigger held.
    a0 = n_accept; d0 = n_done;
    set_ports(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk); trigger = 1'b1;
    repeat (700) @(negedge clk);
    trigger = 1'b0;
    wait_idle();
    exp_n = 699 / (PKT + 1) + 1;
    chk("stream_dones", 32'(n_done - d0), 32'(exp_n));
    chk("stream_accepts", 32'(n_accept - a0), 32'(exp_n));

`ifdef DEBUG_TX_CHECKSUM_EN
    // Checksum packet: trailing byte 7F.
    set_ports(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
    pulse();
    wait_idle();
    chk("csum_pkt_len", last_done - last_accept, 32'd360);
`endif

    // Randomized packets, some with retriggers during busy.
    for (int n = 0; n < 6; n++) begin
      set_ports(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
      pulse();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 250)) @(negedge clk);
        set_ports(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
        pulse();
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
